// File: rtl/lcd_pkg.sv
// Shared constants and scan-state encoding for the LCD region scanner.
package lcd_pkg;
  localparam int NUM_REGIONS = 44;
  localparam int NAME_W      = 40;
  localparam int VALUE_W     = 32;
  localparam int NUM_W       = 6;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SEND  = 2'd2
  } scan_state_t;
endpackage

// File: rtl/lcd_shadow_ram.sv
// Per-region copy of what the LCD currently shows; addressed by region number 1..DEPTH.
module lcd_shadow_ram
  import lcd_pkg::*;
#(
  parameter int DEPTH = lcd_pkg::NUM_REGIONS
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_W-1:0]   addr,
  input  logic               we,
  input  logic               clear_all,
  input  logic               wr_vld,
  input  logic [NAME_W-1:0]  wr_name,
  input  logic [VALUE_W-1:0] wr_value,
  output logic               rd_vld,
  output logic [NAME_W-1:0]  rd_name,
  output logic [VALUE_W-1:0] rd_value
);
  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [DEPTH-1:0]   vld_q;
  logic [NAME_W-1:0]  name_mem  [DEPTH];
  logic [VALUE_W-1:0] value_mem [DEPTH];
  logic [NUM_W-1:0]   idx_full;
  logic [AW-1:0]      idx;
  logic               in_range;

  assign idx_full = addr - NUM_W'(1);
  assign idx      = idx_full[AW-1:0];
  assign in_range = (addr != '0) && (addr <= NUM_W'(DEPTH));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
    end else if (clear_all) begin
      vld_q <= '0;
    end else if (we && in_range) begin
      vld_q[idx] <= wr_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      name_mem[idx]  <= wr_name;
      value_mem[idx] <= wr_value;
    end
  end

  assign rd_vld   = in_range && vld_q[idx];
  assign rd_name  = in_range ? name_mem[idx]  : '0;
  assign rd_value = in_range ? value_mem[idx] : '0;
endmodule

// File: rtl/lcd_display_scan.sv
// Walks display regions 1..NUM_REGIONS, samples user content and forwards only
// regions whose content differs from what was last sent to the renderer.
module lcd_display_scan
  import lcd_pkg::*;
#(
  parameter int NUM_REGIONS = lcd_pkg::NUM_REGIONS,
  parameter int SETTLE      = 1
) (
  input  logic               clk,
  input  logic               resetn,
  output logic [NUM_W-1:0]   display_number,
  input  logic               display_valid,
  input  logic [NAME_W-1:0]  display_name,
  input  logic [VALUE_W-1:0] display_value,
  input  logic               force_refresh,
  output logic               upd_valid,
  input  logic               upd_ready,
  output logic [NUM_W-1:0]   upd_number,
  output logic [NAME_W-1:0]  upd_name,
  output logic [VALUE_W-1:0] upd_value,
  output logic               upd_clear,
  output logic               frame_done
);
  localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  scan_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               refresh_pending;
  logic               capture, advance, xfer, need, wrap, clear_all;

  logic               smp_vld;
  logic [NAME_W-1:0]  smp_name;
  logic [VALUE_W-1:0] smp_value;

  logic               sh_vld;
  logic [NAME_W-1:0]  sh_name;
  logic [VALUE_W-1:0] sh_value;

  lcd_shadow_ram #(.DEPTH(NUM_REGIONS)) u_shadow (
    .clk       (clk),
    .resetn    (resetn),
    .addr      (display_number),
    .we        (xfer),
    .clear_all (clear_all),
    .wr_vld    (smp_vld),
    .wr_name   (smp_name),
    .wr_value  (smp_value),
    .rd_vld    (sh_vld),
    .rd_name   (sh_name),
    .rd_value  (sh_value)
  );

  assign need = (smp_vld && (!sh_vld || (smp_name != sh_name) || (smp_value != sh_value)))
             || (!smp_vld && sh_vld);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    advance = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == CNT_W'(SETTLE)) begin
          capture = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (need) state_d = ST_SEND;
        else      advance = 1'b1;
      end
      ST_SEND: begin
        if (upd_ready) begin
          xfer    = 1'b1;
          advance = 1'b1;
        end
      end
      default: state_d = ST_WAIT;
    endcase
    if (advance) state_d = ST_WAIT;
  end

  assign wrap      = advance && (display_number == NUM_W'(NUM_REGIONS));
  // A refresh request arriving on the wrap edge itself still clears this wrap.
  assign clear_all = wrap && (refresh_pending || force_refresh);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_WAIT;
      cnt_q           <= '0;
      display_number  <= NUM_W'(1);
      refresh_pending <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= wrap;
      if (advance)                        cnt_q <= '0;
      else if (state_q == ST_WAIT && !capture) cnt_q <= cnt_q + CNT_W'(1);
      if (advance) display_number <= wrap ? NUM_W'(1) : display_number + NUM_W'(1);
      if (wrap)               refresh_pending <= 1'b0;
      else if (force_refresh) refresh_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      smp_vld   <= display_valid;
      smp_name  <= display_name;
      smp_value <= display_value;
    end
  end

  // Payload is a view of the held sample, so it cannot move while stalled.
  assign upd_valid  = (state_q == ST_SEND);
  assign upd_number = upd_valid ? display_number : '0;
  assign upd_clear  = upd_valid && !smp_vld;
  assign upd_name   = (upd_valid && smp_vld) ? smp_name  : '0;
  assign upd_value  = (upd_valid && smp_vld) ? smp_value : '0;
endmodule

// File: tb/tb_lcd_display_scan.sv
// Directed bench for lcd_display_scan: frame-level vector table plus stall/refresh/reset sequences.
module tb_lcd_display_scan;
  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  display_number;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic        force_refresh;
  logic        upd_valid;
  logic        upd_ready;
  logic [5:0]  upd_number;
  logic [39:0] upd_name;
  logic [31:0] upd_value;
  logic        upd_clear;
  logic        frame_done;

  lcd_display_scan dut (
    .clk            (clk),
    .resetn         (resetn),
    .display_number (display_number),
    .display_valid  (display_valid),
    .display_name   (display_name),
    .display_value  (display_value),
    .force_refresh  (force_refresh),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_number     (upd_number),
    .upd_name       (upd_name),
    .upd_value      (upd_value),
    .upd_clear      (upd_clear),
    .frame_done     (frame_done)
  );

  always #50 clk = ~clk;

  // User-side content, registered one clock after display_number.
  logic        m_vld   [64];
  logic [39:0] m_name  [64];
  logic [31:0] m_value [64];

  always @(posedge clk) begin
    display_valid <= m_vld[display_number];
    display_name  <= m_name[display_number];
    display_value <= m_value[display_number];
  end

  int          xfer_total = 0;
  logic [5:0]  last_num;
  logic [39:0] last_name;
  logic [31:0] last_value;
  logic        last_clear;

  always @(posedge clk) begin
    if (resetn && upd_valid && upd_ready) begin
      xfer_total = xfer_total + 1;
      last_num   = upd_number;
      last_name  = upd_name;
      last_value = upd_value;
      last_clear = upd_clear;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame_done && cyc < 3000);
    if (!frame_done) check("frame_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_frame(output int n, output int cyc);
    int s;
    s = xfer_total;
    wait_frame(cyc);
    n = xfer_total - s;
  endtask

  task automatic wait_upd(input logic [5:0] num);
    int k;
    k = 0;
    while (!(upd_valid && upd_number == num) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("upd_wait", {63'd0, upd_valid}, 64'd1);
  endtask

  typedef struct {
    int          region;
    logic        vld;
    logic [39:0] name;
    logic [31:0] value;
    int          exp_n;
    logic [5:0]  exp_num;
    logic [39:0] exp_name;
    logic [31:0] exp_value;
    logic        exp_clear;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n, cyc, k, s, bad;
    tbl[0] = '{5,  1'b1, "REG_5", 32'd7,        1, 6'd5,  "REG_5", 32'd7,        1'b0};
    tbl[1] = '{0,  1'b0, 40'd0,   32'd0,        0, 6'd0,  40'd0,   32'd0,        1'b0};
    tbl[2] = '{5,  1'b1, "REG_5", 32'd9,        1, 6'd5,  "REG_5", 32'd9,        1'b0};
    tbl[3] = '{3,  1'b1, "REG_3", 32'h33,       1, 6'd3,  "REG_3", 32'h33,       1'b0};
    tbl[4] = '{3,  1'b0, "REG_3", 32'h33,       1, 6'd3,  40'd0,   32'd0,        1'b1};
    tbl[5] = '{0,  1'b0, 40'd0,   32'd0,        0, 6'd0,  40'd0,   32'd0,        1'b0};
    tbl[6] = '{44, 1'b1, "LAST_", 32'hDEADBEEF, 1, 6'd44, "LAST_", 32'hDEADBEEF, 1'b0};
    tbl[7] = '{5,  1'b1, "RGN_5", 32'd9,        1, 6'd5,  "RGN_5", 32'd9,        1'b0};
    tbl[8] = '{44, 1'b1, "LAST_", 32'hDEADBEEF, 0, 6'd0,  40'd0,   32'd0,        1'b0};
    tbl[9] = '{3,  1'b0, "XXXXX", 32'h77,       0, 6'd0,  40'd0,   32'd0,        1'b0};

    for (int i = 0; i < 64; i++) begin
      m_vld[i] = 1'b0;
      m_name[i] = '0;
      m_value[i] = '0;
    end
    m_vld[1] = 1'b1;
    m_name[1] = "ADD_1";
    m_value[1] = 32'd5;

    resetn = 1'b0;
    force_refresh = 1'b0;
    upd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_display_number", {58'd0, display_number}, 64'd1);
    check("rst_upd_valid", {63'd0, upd_valid}, 64'd0);
    check("rst_upd_payload", {upd_clear, upd_number, upd_name, upd_value[16:0]}, 64'd0);
    check("rst_frame_done", {63'd0, frame_done}, 64'd0);
    resetn = 1'b1;

    // First frame after reset: only region 1 is sent.
    run_frame(n, cyc);
    check("f1_updates", n, 1);
    check("f1_cycles", cyc, 133);
    check("f1_number", {58'd0, last_num}, 64'd1);
    check("f1_name", {24'd0, last_name}, {24'd0, 40'("ADD_1")});
    check("f1_value", {32'd0, last_value}, 64'd5);
    check("f1_clear", {63'd0, last_clear}, 64'd0);
    @(negedge clk);
    check("frame_done_width", {63'd0, frame_done}, 64'd0);
    run_frame(n, cyc);
    check("f2_updates", n, 0);
    check("f2_cycles", cyc, 131);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].region != 0) begin
        m_vld[tbl[i].region]   = tbl[i].vld;
        m_name[tbl[i].region]  = tbl[i].name;
        m_value[tbl[i].region] = tbl[i].value;
      end
      run_frame(n, cyc);
      check($sformatf("v%0d_updates", i), n, tbl[i].exp_n);
      check($sformatf("v%0d_cycles", i), cyc, 132 + tbl[i].exp_n);
      if (tbl[i].exp_n != 0) begin
        check($sformatf("v%0d_number", i), {58'd0, last_num}, {58'd0, tbl[i].exp_num});
        check($sformatf("v%0d_name", i), {24'd0, last_name}, {24'd0, tbl[i].exp_name});
        check($sformatf("v%0d_value", i), {32'd0, last_value}, {32'd0, tbl[i].exp_value});
        check($sformatf("v%0d_clear", i), {63'd0, last_clear}, {63'd0, tbl[i].exp_clear});
      end
    end

    // Refresh requested mid-frame: no effect until the wrap, then 3 valid regions resent.
    k = 0;
    while (display_number != 6'd10 && k < 200) begin
      @(negedge clk);
      k++;
    end
    s = xfer_total;
    force_refresh = 1'b1;
    @(negedge clk);
    force_refresh = 1'b0;
    wait_frame(cyc);
    check("refresh_rest_of_frame", xfer_total - s, 0);
    run_frame(n, cyc);
    check("refresh_next_frame", n, 3);
    run_frame(n, cyc);
    check("refresh_after", n, 0);

    // Backpressure: 20 stalled cycles must hold number and payload.
    upd_ready = 1'b0;
    m_value[5] = 32'h1234;
    wait_upd(6'd5);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (!(upd_valid && display_number == 6'd5 && upd_number == 6'd5 &&
            upd_value == 32'h1234 && upd_name == 40'("RGN_5"))) bad++;
      @(negedge clk);
    end
    check("stall_stable_cycles_bad", bad, 0);
    s = xfer_total;
    upd_ready = 1'b1;
    @(negedge clk);
    check("stall_xfer", xfer_total - s, 1);
    check("stall_value", {32'd0, last_value}, 64'h1234);
    check("stall_upd_valid_drop", {63'd0, upd_valid}, 64'd0);
    check("stall_advance", {58'd0, display_number}, 64'd6);
    wait_frame(cyc);

    // Reset during SEND aborts the record; first frame afterwards resends everything.
    upd_ready = 1'b0;
    m_value[44] = 32'hCAFE0044;
    wait_upd(6'd44);
    resetn = 1'b0;
    #1;
    check("rst_send_upd_valid", {63'd0, upd_valid}, 64'd0);
    check("rst_send_number", {58'd0, display_number}, 64'd1);
    @(negedge clk);
    upd_ready = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    run_frame(n, cyc);
    check("post_rst_updates", n, 3);
    check("post_rst_cycles", cyc, 135);
    check("post_rst_last_number", {58'd0, last_num}, 64'd44);
    check("post_rst_last_value", {32'd0, last_value}, 64'hCAFE0044);
    run_frame(n, cyc);
    check("post_rst_quiet", n, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/lcd_display_scan.md
LCD_DISPLAY_SCAN -- requirements
Module: lcd_display_scan

Interface
REQ-001 Parameter NUM_REGIONS, default 44: number of display regions scanned, numbered 1..NUM_REGIONS.
REQ-002 Parameter SETTLE, default 1: extra wait cycles after display_number changes, before sampling.
REQ-003 clk  input  1  single system clock (10 MHz); all state changes on its rising edge.
REQ-004 resetn  input  1  reset; asynchronous, active-low.
REQ-005 display_number  output  6  region currently requested from user logic.
REQ-006 display_valid  input  1  user logic: region display_number has content.
REQ-007 display_name  input  40  user logic: 5 ASCII characters, MSB byte = first character.
REQ-008 display_value  input  32  user logic: 32-bit value for the region.
REQ-009 force_refresh  input  1  single-cycle pulse: re-send every region on the next frame.
REQ-010 upd_valid  output  1  update record available to the LCD text renderer.
REQ-011 upd_ready  input  1  renderer accepts the record.
REQ-012 upd_number  output  6  region being updated.
REQ-013 upd_name  output  40  name to draw.
REQ-014 upd_value  output  32  value to draw.
REQ-015 upd_clear  output  1  region became invalid; the renderer blanks it, and name and value are 0.
REQ-016 frame_done  output  1  one-cycle pulse after region NUM_REGIONS completes.

Function
REQ-017 The block SHALL initiate the display_number protocol: user logic registers its name, value and valid outputs one clk after display_number changes.
REQ-018 States SHALL be: WAIT (number stable, counter 0..SETTLE), CHECK (compare, 1 cycle), SEND (handshake).
REQ-019 WAIT: when counter==SETTLE, capture display_valid, display_name and display_value into sample registers; next state CHECK.
REQ-020 CHECK: an update is needed if (sample valid and (shadow invalid, or name differs, or value differs)) or (sample invalid and shadow valid); if needed, go to SEND, else advance.
REQ-021 SEND: upd_valid=1 with payload taken from the sample registers; payload is stable while upd_valid=1 and upd_ready=0.
REQ-022 SEND transfer occurs on an edge with upd_valid=1 and upd_ready=1; on that edge the shadow entry is written, upd_valid drops next cycle, and the block advances.
REQ-023 Advance SHALL set display_number = display_number+1, or 1 after NUM_REGIONS, and return to WAIT with counter 0.
REQ-024 display_number SHALL NOT change while in SEND, regardless of how long upd_ready stays low.
REQ-025 Unchanged region cost SHALL be exactly SETTLE+2 cycles; with defaults, an all-unchanged frame is 132 cycles.
REQ-026 frame_done SHALL pulse for exactly 1 cycle on the advance from NUM_REGIONS to 1.
REQ-027 force_refresh SHALL latch into refresh_pending at any time; at the next wrap to region 1, all shadow valid bits clear and pending clears.
REQ-028 force_refresh coinciding with the wrap edge SHALL take effect on that wrap.
REQ-029 While refresh is pending, the in-progress frame SHALL continue using unchanged compare rules.
REQ-030 Sample invalid and shadow invalid SHALL produce no update.
REQ-031 Sample valid and shadow valid with identical name and value SHALL produce no update.

Reset
REQ-032 On resetn=0, outputs SHALL immediately become: display_number=1, upd_valid=0, upd_clear=0, upd_number=0, upd_name=0, upd_value=0, frame_done=0.
REQ-033 On resetn=0, internal state SHALL become: state=WAIT, counter=0, refresh_pending=0, all shadow valid bits=0.
REQ-034 Reset mid-SEND SHALL abort the record without a shadow write, and the first frame after reset sends every valid region.

Structure
REQ-035 Shared package lcd_pkg SHALL hold: NUM_REGIONS, NAME_W=40, VALUE_W=32, NUM_W=6, state encodings.
REQ-036 Sub-module lcd_shadow_ram SHALL be NUM_REGIONS x (1+40+32) bits, with synchronous write, combinational read addressed by display_number, and valid bits in flops with async clear.

Verification
REQ-037 After reset, region 1 gives valid, "ADD_1", 0x00000005, and others are invalid; with upd_ready=1, exactly one update (1, "ADD_1", 5) SHALL occur, frame_done SHALL pulse, and the second frame has no updates.
REQ-038 Region 5 value changes 7 -> 9 mid-frame; the next visit to region 5 SHALL produce one update with upd_value=9.
REQ-039 upd_ready is held 0 for 20 cycles in SEND; display_number and payload SHALL stay constant, and transfer and advance SHALL occur on the first cycle upd_ready=1.
REQ-040 Region 3 goes from valid to invalid; one update SHALL occur with upd_clear=1, upd_number=3, name=0, value=0, and no further updates on later frames.
REQ-041 force_refresh is pulsed mid-frame with 3 valid regions; the rest of the current frame SHALL produce no updates, and the next frame SHALL produce exactly 3 updates.
REQ-042 resetn asserted while upd_valid=1 SHALL immediately give upd_valid=0 and display_number=1, and the pending region SHALL be re-sent in the first frame after release.
